keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner. Drives one-hot row strobes, synchronises and debounces the column sense lines, and decodes the pressed key. Emits a one-cycle key_valid pulse per debounced press, a key_held level, and a key_released pulse. It sits between the keypad pins and the display/entry logic, and supersedes the bare combinational key decode with scanning, debounce and press/release tracking.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/keypad_scanner_sync2.sv | 24 ++
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// State encoding, hex legend lookup and column bit counting.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  function automatic logic [3:0] hex_map(
    input logic [1:0] row_idx,
    input logic [1:0] col_idx
  );
    case ({row_idx, col_idx})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      4'hF: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic int unsigned onehot_count(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports: clk, reset_n (async active-low), d (raw), q (synchronised).
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobe, column sync, debounce, decode.
// Ports: clk, reset_n, col_in -> row_drive, key_code, key_valid/held/released.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HEX_MAP         = 1,
  parameter int CODE_W          = $clog2(NROWS * NCOLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCOLS-1:0]  col_in,
  output logic [NROWS-1:0]  row_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_released
);

  localparam int RW   = $clog2(NROWS);
  localparam int CIW  = $clog2(NCOLS);
  localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                        SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNTW = $clog2(MAXC);

  localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_CYCLES - 1);
  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]   ROW_LAST  = RW'(NROWS - 1);

  if (HEX_MAP == 1 && (NROWS != 4 || NCOLS != 4)) begin : g_map_chk
    $error("keypad_scanner: HEX_MAP=1 needs NROWS=NCOLS=4");
  end
  if (NCOLS > 32) begin : g_col_chk
    $error("keypad_scanner: NCOLS must be <= 32");
  end

  logic [NCOLS-1:0] col_s;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [NCOLS-1:0]  hot_q, hot_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              rel_q, rel_d;

  logic [RW-1:0]     row_nxt;
  logic [CNTW-1:0]   cnt_inc;
  logic [CIW-1:0]    col_idx;
  logic [CODE_W-1:0] code_new;
  logic              hot_bit;

  sync2 #(
    .W (NCOLS)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (col_in),
    .q       (col_s)
  );

  always_comb begin
    row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    hot_bit = |(col_s & hot_q);
    col_idx = '0;
    for (int j = 0; j < NCOLS; j++) begin
      if (hot_q[j]) col_idx = CIW'(j);
    end
    if (HEX_MAP == 1)
      code_new = CODE_W'(hex_map(2'(row_q), 2'(col_idx)));
    else
      code_new = CODE_W'(int'(row_q) * NCOLS + int'(col_idx));
    row_drive = '0;
    for (int i = 0; i < NROWS; i++) begin
      row_drive[NROWS-1-i] = (row_q == RW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    row_d   = row_q;
    hot_d   = hot_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    rel_d   = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          // ghost / multi-key patterns are skipped like an idle row
          if (onehot_count(32'(col_s)) == 1) begin
            hot_d   = col_s;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_nxt;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != hot_q) begin
          state_d = SCAN;
          row_d   = row_nxt;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          code_d  = code_new;
          valid_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!hot_bit) state_d = RELEASE;
      end
      RELEASE: begin
        if (hot_bit) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_nxt;
          rel_d   = 1'b1;
          held_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      row_q   <= '0;
      hot_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      hot_q   <= hot_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
    end
  end

  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_held     = held_q;
  assign key_released = rel_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: 4x4 hex instance and 2x3 raw instance.
// Stimulus pushes expected codes; monitors pop on key_valid/key_released.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] col_in, row_drive, key_code;
  logic       key_valid, key_held, key_released;
  logic [2:0] col2, code2;
  logic [1:0] row2;
  logic       v2, h2, r2;

  bit dn  [4][4];
  bit dn2 [2][3];

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$], rel_q[$];
  logic [2:0] exp2_q[$], rel2_q[$];

  localparam logic [3:0] LEGEND [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  keypad_scanner #(
    .NROWS (4), .NCOLS (4),
    .SCAN_CYCLES (4), .DEBOUNCE_CYCLES (8),
    .HEX_MAP (1)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .col_in       (col_in),
    .row_drive    (row_drive),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held),
    .key_released (key_released)
  );

  keypad_scanner #(
    .NROWS (2), .NCOLS (3),
    .SCAN_CYCLES (4), .DEBOUNCE_CYCLES (8),
    .HEX_MAP (0)
  ) u_raw (
    .clk          (clk),
    .reset_n      (reset_n),
    .col_in       (col2),
    .row_drive    (row2),
    .key_code     (code2),
    .key_valid    (v2),
    .key_held     (h2),
    .key_released (r2)
  );

  // closed switch connects the driven row to its column
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (dn[r][c] && row_drive[3-r]) col_in[c] = 1'b1;
  end

  always_comb begin
    col2 = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        if (dn2[r][c] && row2[1-r]) col2[c] = 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic spurious(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s got code=%0h want no pulse", nm, act);
  endtask

  always @(negedge clk) begin
    if (reset_n && (key_valid || key_released)) begin
      chk("vld_rel_excl", 32'(key_valid & key_released), 32'd0);
      if (key_valid) begin
        if (exp_q.size() == 0) spurious("spurious_valid", 32'(key_code));
        else begin
          chk("key_code", 32'(key_code), 32'(exp_q.pop_front()));
          chk("held_at_valid", 32'(key_held), 32'd1);
        end
      end
      if (key_released) begin
        if (rel_q.size() == 0) spurious("spurious_rel", 32'(key_code));
        else begin
          chk("rel_code", 32'(key_code), 32'(rel_q.pop_front()));
          chk("held_at_rel", 32'(key_held), 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && (v2 || r2)) begin
      chk("vld_rel_excl2", 32'(v2 & r2), 32'd0);
      if (v2) begin
        if (exp2_q.size() == 0) spurious("spurious_valid2", 32'(code2));
        else chk("key_code2", 32'(code2), 32'(exp2_q.pop_front()));
      end
      if (r2) begin
        if (rel2_q.size() == 0) spurious("spurious_rel2", 32'(code2));
        else chk("rel_code2", 32'(code2), 32'(rel2_q.pop_front()));
      end
    end
  end

  function automatic int qsize(input int sel);
    case (sel)
      0: return exp_q.size();
      1: return rel_q.size();
      2: return exp2_q.size();
      default: return rel2_q.size();
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int sel, input int maxc, input string nm);
    int n;
    n = 0;
    while (qsize(sel) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (qsize(sel) != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d want 0", nm, qsize(sel));
      case (sel)
        0: exp_q.delete();
        1: rel_q.delete();
        2: exp2_q.delete();
        default: rel2_q.delete();
      endcase
    end
  endtask

  task automatic wait_row(input logic [3:0] v);
    int n;
    n = 0;
    while (row_drive == v && n < 100) begin cyc(1); n++; end
    n = 0;
    while (row_drive != v && n < 100) begin cyc(1); n++; end
    chk("wait_row", 32'(row_drive), 32'(v));
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code);
    exp_q.push_back(code);
    dn[r][c] = 1'b1;
    drain(0, 80, "press");
    rel_q.push_back(code);
    dn[r][c] = 1'b0;
    drain(1, 40, "release");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    int n;
    reset_n = 1'b0;
    cyc(2);
    chk("rst_row", 32'(row_drive), 32'h8);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_rel", 32'(key_released), 32'h0);
    chk("rst_row2", 32'(row2), 32'h2);
    reset_n = 1'b1;

    for (int k = 0; k <= 16; k++) begin
      e = 4'b1000 >> ((k / 4) % 4);
      chk("row_scan", 32'(row_drive), 32'(e));
      cyc(1);
    end
    chk("idle_held", 32'(key_held), 32'h0);

    exp_q.push_back(4'h5);
    dn[1][1] = 1'b1;
    drain(0, 80, "press_5");
    cyc(4);
    chk("held_5", 32'(key_held), 32'h1);
    rel_q.push_back(4'h5);
    dn[1][1] = 1'b0;
    drain(1, 40, "rel_5");
    cyc(1);
    chk("held_off_5", 32'(key_held), 32'h0);

    for (int i = 0; i < 16; i++) press(i / 4, i % 4, LEGEND[i]);

    wait_row(4'b0010);
    dn[2][0] = 1'b1;
    cyc(3);
    dn[2][0] = 1'b0;
    cyc(1);
    exp_q.push_back(4'h7);
    dn[2][0] = 1'b1;
    drain(0, 80, "press_7");
    cyc(3);
    dn[2][0] = 1'b0;
    cyc(2);
    dn[2][0] = 1'b1;
    cyc(30);
    chk("held_glitch", 32'(key_held), 32'h1);
    chk("code_glitch", 32'(key_code), 32'h7);
    rel_q.push_back(4'h7);
    dn[2][0] = 1'b0;
    drain(1, 40, "rel_7");

    exp_q.push_back(4'h1);
    dn[0][0] = 1'b1;
    drain(0, 80, "press_1");
    dn[2][2] = 1'b1;
    cyc(40);
    chk("held_1", 32'(key_held), 32'h1);
    chk("code_1", 32'(key_code), 32'h1);
    rel_q.push_back(4'h1);
    exp_q.push_back(4'h9);
    dn[0][0] = 1'b0;
    drain(1, 40, "rel_1");
    drain(0, 80, "press_9");
    chk("code_9", 32'(key_code), 32'h9);
    rel_q.push_back(4'h9);
    dn[2][2] = 1'b0;
    drain(1, 40, "rel_9");

    dn[0][1] = 1'b1;
    n = 0;
    while (u_dut.state_q != DEBOUNCE && n < 80) begin cyc(1); n++; end
    chk("in_debounce", 32'(u_dut.state_q == DEBOUNCE), 32'h1);
    cyc(3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_row", 32'(row_drive), 32'h8);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_held", 32'(key_held), 32'h0);
    dn[0][1] = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(40);
    chk("post_rst_code", 32'(key_code), 32'h0);

    exp2_q.push_back(3'd5);
    dn2[1][2] = 1'b1;
    drain(2, 60, "press_raw5");
    cyc(2);
    chk("held_raw", 32'(h2), 32'h1);
    rel2_q.push_back(3'd5);
    dn2[1][2] = 1'b0;
    drain(3, 40, "rel_raw5");
    cyc(2);
    chk("held_raw_off", 32'(h2), 32'h0);

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
